wb_arbiter: RTL and testbench

Register-file write-port arbiter for the CPU pipeline. Shares the single regfile write port between the MEM-stage writeback (`mem_we`/`mem_addr`/`mem_data`) and a multi-cycle unit such as a divider or load unit with a valid/ready handshake. Multi-cycle results are buffered in a small FIFO. The arbiter also prevents starvation by requesting a one-cycle pipeline stall, and exports a pending-address mask so decode can interlock on queued writes.

---
 rtl/wb_arbiter.sv | 160 ++++++++++++++++
 tb/tb_wb_arbiter.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_arbiter.sv
// Regfile write-port arbiter: MEM-stage writeback vs. a FIFO-buffered multi-cycle unit.
// Define WB_ARB_BYPASS_EN to let a B result skip an empty, idle FIFO for 1-cycle latency.
module wb_arbiter #(
  parameter int DEPTH        = 4,
  parameter int STARVE_LIMIT = 8
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        mem_we,
  input  logic [4:0]  mem_addr,
  input  logic [31:0] mem_data,
  input  logic        b_valid,
  input  logic [4:0]  b_addr,
  input  logic [31:0] b_data,
  output logic        b_ready,
  output logic        stall_req,
  output logic [31:0] pend_mask,
  output logic        wb_we,
  output logic [4:0]  wb_addr,
  output logic [31:0] wb_data
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(STARVE_LIMIT + 1);
  localparam logic [PTR_W:0]   FULL_CNT  = (PTR_W + 1)'(DEPTH);
  localparam logic [CNT_W-1:0] LIMIT_CNT = CNT_W'(STARVE_LIMIT);

  function automatic logic [31:0] addr_onehot(input logic [4:0] addr);
    return 32'd1 << addr;
  endfunction

  logic [4:0]       fifo_addr [DEPTH];
  logic [31:0]      fifo_data [DEPTH];
  logic [DEPTH-1:0] fifo_vld;
  logic [DEPTH-1:0] fifo_vld_nxt;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W:0]   fifo_cnt;
  logic [CNT_W-1:0] starve_cnt;
  logic             stall_q;

  logic             full;
  logic             empty;
  logic             push;
  logic             pop;
  logic             bypass;
  logic             gnt_vld_p0;
  logic [4:0]       gnt_addr_p0;
  logic [31:0]      gnt_data_p0;

  assign full      = (fifo_cnt == FULL_CNT);
  assign empty     = (fifo_cnt == '0);
  assign b_ready   = !full;
  assign stall_req = stall_q;

`ifdef WB_ARB_BYPASS_EN
  assign bypass = empty && !mem_we && !stall_q && b_valid;
`else
  assign bypass = 1'b0;
`endif

  // A bypassed B result goes straight to the output register and never occupies a slot.
  assign push = b_valid && !full && !bypass;

  // Stage p0: grant selection
  always_comb begin
    pop         = 1'b0;
    gnt_vld_p0  = 1'b0;
    gnt_addr_p0 = '0;
    gnt_data_p0 = '0;
    if (stall_q) begin
      pop = !empty;
    end else if (mem_we) begin
      gnt_vld_p0  = 1'b1;
      gnt_addr_p0 = mem_addr;
      gnt_data_p0 = mem_data;
    end else if (!empty) begin
      pop = 1'b1;
    end else if (bypass) begin
      gnt_vld_p0  = 1'b1;
      gnt_addr_p0 = b_addr;
      gnt_data_p0 = b_data;
    end
    if (pop) begin
      gnt_vld_p0  = 1'b1;
      gnt_addr_p0 = fifo_addr[rd_ptr];
      gnt_data_p0 = fifo_data[rd_ptr];
    end
  end

  always_comb begin
    pend_mask = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (fifo_vld[i]) pend_mask = pend_mask | addr_onehot(fifo_addr[i]);
    end
  end

  always_comb begin
    fifo_vld_nxt = fifo_vld;
    if (pop)  fifo_vld_nxt[rd_ptr] = 1'b0;
    if (push) fifo_vld_nxt[wr_ptr] = 1'b1;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      fifo_cnt <= '0;
      fifo_vld <= '0;
    end else begin
      fifo_vld <= fifo_vld_nxt;
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      unique case ({push, pop})
        2'b10:   fifo_cnt <= fifo_cnt + 1'b1;
        2'b01:   fifo_cnt <= fifo_cnt - 1'b1;
        default: fifo_cnt <= fifo_cnt;
      endcase
    end
  end

  // Entry payload is only observed through fifo_vld, so it needs no reset.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_addr[wr_ptr] <= b_addr;
      fifo_data[wr_ptr] <= b_data;
    end
  end

  // The counter saturates at the limit; the stall cycle pops the head, which clears it.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      starve_cnt <= '0;
      stall_q    <= 1'b0;
    end else begin
      stall_q <= (starve_cnt == LIMIT_CNT) && !stall_q;
      if (empty || pop) begin
        starve_cnt <= '0;
      end else if (starve_cnt != LIMIT_CNT) begin
        starve_cnt <= starve_cnt + 1'b1;
      end
    end
  end

  // Stage p1: regfile write register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wb_we   <= 1'b0;
      wb_addr <= '0;
      wb_data <= '0;
    end else begin
      wb_we <= gnt_vld_p0 && (gnt_addr_p0 != 5'd0);
      if (gnt_vld_p0) begin
        wb_addr <= gnt_addr_p0;
        wb_data <= gnt_data_p0;
      end
    end
  end

endmodule

// File: tb/tb_wb_arbiter.sv
// Scoreboard bench for wb_arbiter: expected regfile writes are queued as stimulus is driven
// and compared against the writes collected from wb_* at the end of each scenario.
module tb_wb_arbiter;

  localparam int DEPTH        = 4;
  localparam int STARVE_LIMIT = 8;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        mem_we;
  logic [4:0]  mem_addr;
  logic [31:0] mem_data;
  logic        b_valid;
  logic [4:0]  b_addr;
  logic [31:0] b_data;
  logic        b_ready;
  logic        stall_req;
  logic [31:0] pend_mask;
  logic        wb_we;
  logic [4:0]  wb_addr;
  logic [31:0] wb_data;

  logic [36:0] exp_q[$];
  logic [36:0] obs_q[$];
  int n_checks = 0;
  int n_pass   = 0;

  wb_arbiter #(.DEPTH(DEPTH), .STARVE_LIMIT(STARVE_LIMIT)) dut (
    .clk(clk), .reset_n(reset_n),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_data(mem_data),
    .b_valid(b_valid), .b_addr(b_addr), .b_data(b_data), .b_ready(b_ready),
    .stall_req(stall_req), .pend_mask(pend_mask),
    .wb_we(wb_we), .wb_addr(wb_addr), .wb_data(wb_data)
  );

  always #5 clk = ~clk;

  // One clock: inputs set before the rising edge, outputs collected on the falling edge.
  task automatic cyc();
    @(posedge clk);
    @(negedge clk);
    if (reset_n && wb_we) obs_q.push_back({wb_addr, wb_data});
  endtask

  task automatic idle_inputs();
    mem_we = 1'b0; mem_addr = '0; mem_data = '0;
    b_valid = 1'b0; b_addr = '0; b_data = '0;
  endtask

  task automatic test_reset();
    idle_inputs();
    reset_n = 1'b0;
    repeat (2) cyc();
    n_checks++; if (b_ready !== 1'b1) $display("FAIL rst_b_ready: got %b required 1", b_ready); else n_pass++;
    n_checks++; if (stall_req !== 1'b0) $display("FAIL rst_stall: got %b required 0", stall_req); else n_pass++;
    n_checks++; if (pend_mask !== 32'h0) $display("FAIL rst_pend: got %h required 0", pend_mask); else n_pass++;
    n_checks++; if ({wb_we, wb_addr, wb_data} !== 38'h0) $display("FAIL rst_wb: got we=%b addr=%0d data=%h required all 0", wb_we, wb_addr, wb_data); else n_pass++;
    reset_n = 1'b1;
    cyc();
  endtask

  task automatic test_priority();
    logic [36:0] o, e;
    mem_we = 1'b1; mem_addr = 5'd3; mem_data = 32'h11;
    b_valid = 1'b1; b_addr = 5'd5; b_data = 32'h22;
    exp_q.push_back({5'd3, 32'h11});
    cyc();
    n_checks++; if ({wb_we, wb_addr} !== {1'b1, 5'd3}) $display("FAIL prio_mem_first: got we=%b addr=%0d required we=1 addr=3", wb_we, wb_addr); else n_pass++;
    n_checks++; if (pend_mask !== 32'h20) $display("FAIL prio_pend_set: got %h required 00000020", pend_mask); else n_pass++;
    mem_addr = 5'd4; mem_data = 32'h33; b_valid = 1'b0;
    exp_q.push_back({5'd4, 32'h33});
    cyc();
    n_checks++; if (pend_mask !== 32'h20) $display("FAIL prio_pend_held: got %h required 00000020", pend_mask); else n_pass++;
    mem_we = 1'b0;
    exp_q.push_back({5'd5, 32'h22});
    cyc();
    n_checks++; if ({wb_we, wb_addr, wb_data} !== {1'b1, 5'd5, 32'h22}) $display("FAIL prio_b_write: got we=%b addr=%0d data=%h required we=1 addr=5 data=22", wb_we, wb_addr, wb_data); else n_pass++;
    n_checks++; if (pend_mask !== 32'h0) $display("FAIL prio_pend_clear: got %h required 0", pend_mask); else n_pass++;
    repeat (2) cyc();
    n_checks++; if (obs_q.size() != exp_q.size()) $display("FAIL prio_sb_count: got %0d writes required %0d", obs_q.size(), exp_q.size()); else n_pass++;
    while (obs_q.size() > 0 && exp_q.size() > 0) begin
      o = obs_q.pop_front(); e = exp_q.pop_front(); n_checks++;
      if (o !== e) $display("FAIL prio_sb_write: got r%0d=%h required r%0d=%h", o[36:32], o[31:0], e[36:32], e[31:0]); else n_pass++;
    end
    obs_q.delete(); exp_q.delete();
  endtask

  task automatic test_full();
    logic [36:0] o, e;
    for (int i = 0; i < DEPTH; i++) begin
      mem_we = 1'b1; mem_addr = 5'd1; mem_data = 32'(32'h1000 + i);
      b_valid = 1'b1; b_addr = 5'(8 + i); b_data = 32'(32'h200 + i);
      exp_q.push_back({5'd1, 32'(32'h1000 + i)});
      cyc();
    end
    n_checks++; if (b_ready !== 1'b0) $display("FAIL full_b_ready: got %b required 0", b_ready); else n_pass++;
    n_checks++; if (pend_mask !== 32'h0F00) $display("FAIL full_pend: got %h required 00000f00", pend_mask); else n_pass++;
    mem_data = 32'h1004; b_addr = 5'd12; b_data = 32'h2FF;
    exp_q.push_back({5'd1, 32'h1004});
    cyc();
    n_checks++; if (b_ready !== 1'b0) $display("FAIL full_5th_b_ready: got %b required 0", b_ready); else n_pass++;
    n_checks++; if (pend_mask !== 32'h0F00) $display("FAIL full_5th_rejected: got %h required 00000f00", pend_mask); else n_pass++;
    mem_we = 1'b0; b_valid = 1'b0;
    for (int k = 0; k < DEPTH; k++) exp_q.push_back({5'(8 + k), 32'(32'h200 + k)});
    for (int k = 0; k < DEPTH; k++) begin
      cyc();
      n_checks++; if ({wb_we, wb_addr} !== {1'b1, 5'(8 + k)}) $display("FAIL full_drain_%0d: got we=%b addr=%0d required we=1 addr=%0d", k, wb_we, wb_addr, 8 + k); else n_pass++;
      if (k == 0) begin
        n_checks++; if (b_ready !== 1'b1) $display("FAIL full_b_ready_rise: got %b required 1", b_ready); else n_pass++;
      end
    end
    n_checks++; if (pend_mask !== 32'h0) $display("FAIL full_pend_empty: got %h required 0", pend_mask); else n_pass++;
    cyc();
    n_checks++; if (obs_q.size() != exp_q.size()) $display("FAIL full_sb_count: got %0d writes required %0d", obs_q.size(), exp_q.size()); else n_pass++;
    while (obs_q.size() > 0 && exp_q.size() > 0) begin
      o = obs_q.pop_front(); e = exp_q.pop_front(); n_checks++;
      if (o !== e) $display("FAIL full_sb_write: got r%0d=%h required r%0d=%h", o[36:32], o[31:0], e[36:32], e[31:0]); else n_pass++;
    end
    obs_q.delete(); exp_q.delete();
  endtask

  task automatic test_starvation();
    logic [36:0] o, e;
    int stall_n;
    int stall_at;
    stall_n = 0; stall_at = -1;
    for (int c = 0; c < 14; c++) begin
      mem_we = 1'b1; mem_addr = 5'd2; mem_data = 32'(32'h500 + c);
      b_valid = (c == 0); b_addr = 5'd6; b_data = 32'h66;
      // Head reaches the limit in cycle 9, so cycle 10 is the stall cycle that drops the MEM write.
      if (c == 10) exp_q.push_back({5'd6, 32'h66});
      else         exp_q.push_back({5'd2, 32'(32'h500 + c)});
      if (stall_req) begin stall_n++; stall_at = c; end
      if (c == 10) begin
        n_checks++; if (pend_mask !== 32'h40) $display("FAIL starve_pend_held: got %h required 00000040", pend_mask); else n_pass++;
      end
      if (c == 11) begin
        n_checks++; if (pend_mask !== 32'h0) $display("FAIL starve_pend_clear: got %h required 0", pend_mask); else n_pass++;
      end
      cyc();
    end
    n_checks++; if (stall_n != 1) $display("FAIL starve_stall_len: got %0d cycles required 1", stall_n); else n_pass++;
    n_checks++; if (stall_at != 10) $display("FAIL starve_stall_cycle: got %0d required 10", stall_at); else n_pass++;
    mem_we = 1'b0; b_valid = 1'b0;
    repeat (2) cyc();
    n_checks++; if (obs_q.size() != exp_q.size()) $display("FAIL starve_sb_count: got %0d writes required %0d", obs_q.size(), exp_q.size()); else n_pass++;
    while (obs_q.size() > 0 && exp_q.size() > 0) begin
      o = obs_q.pop_front(); e = exp_q.pop_front(); n_checks++;
      if (o !== e) $display("FAIL starve_sb_write: got r%0d=%h required r%0d=%h", o[36:32], o[31:0], e[36:32], e[31:0]); else n_pass++;
    end
    obs_q.delete(); exp_q.delete();
  endtask

  task automatic test_r0();
    logic [36:0] o, e;
    mem_we = 1'b1; mem_addr = 5'd0; mem_data = 32'hDEAD;
    b_valid = 1'b1; b_addr = 5'd0; b_data = 32'h77;
    cyc();
    n_checks++; if (wb_we !== 1'b0) $display("FAIL r0_mem_we: got %b required 0", wb_we); else n_pass++;
    n_checks++; if (pend_mask !== 32'h1) $display("FAIL r0_pend_set: got %h required 00000001", pend_mask); else n_pass++;
    mem_we = 1'b0; b_valid = 1'b0;
    cyc();
    n_checks++; if (wb_we !== 1'b0) $display("FAIL r0_fifo_we: got %b required 0", wb_we); else n_pass++;
    n_checks++; if (pend_mask !== 32'h0) $display("FAIL r0_pend_clear: got %h required 0", pend_mask); else n_pass++;
    n_checks++; if (wb_data !== 32'h77) $display("FAIL r0_popped: got data %h required 00000077", wb_data); else n_pass++;
    cyc();
    n_checks++; if (obs_q.size() != exp_q.size()) $display("FAIL r0_sb_count: got %0d writes required %0d", obs_q.size(), exp_q.size()); else n_pass++;
    while (obs_q.size() > 0 && exp_q.size() > 0) begin
      o = obs_q.pop_front(); e = exp_q.pop_front(); n_checks++;
      if (o !== e) $display("FAIL r0_sb_write: got r%0d=%h required r%0d=%h", o[36:32], o[31:0], e[36:32], e[31:0]); else n_pass++;
    end
    obs_q.delete(); exp_q.delete();
  endtask

  task automatic test_bypass();
    logic [36:0] o, e;
    b_valid = 1'b1; b_addr = 5'd7; b_data = 32'h7777;
    exp_q.push_back({5'd7, 32'h7777});
    cyc();
    b_valid = 1'b0;
`ifdef WB_ARB_BYPASS_EN
    n_checks++; if ({wb_we, wb_addr} !== {1'b1, 5'd7}) $display("FAIL byp_write: got we=%b addr=%0d required we=1 addr=7", wb_we, wb_addr); else n_pass++;
    n_checks++; if (pend_mask !== 32'h0) $display("FAIL byp_pend: got %h required 0", pend_mask); else n_pass++;
    cyc();
    n_checks++; if (wb_we !== 1'b0) $display("FAIL byp_single: got %b required 0", wb_we); else n_pass++;
`else
    n_checks++; if (wb_we !== 1'b0) $display("FAIL nobyp_early: got %b required 0", wb_we); else n_pass++;
    n_checks++; if (pend_mask !== 32'h80) $display("FAIL nobyp_pend: got %h required 00000080", pend_mask); else n_pass++;
    cyc();
    n_checks++; if ({wb_we, wb_addr} !== {1'b1, 5'd7}) $display("FAIL nobyp_write: got we=%b addr=%0d required we=1 addr=7", wb_we, wb_addr); else n_pass++;
    n_checks++; if (pend_mask !== 32'h0) $display("FAIL nobyp_pend_clear: got %h required 0", pend_mask); else n_pass++;
`endif
    cyc();
    n_checks++; if (obs_q.size() != exp_q.size()) $display("FAIL byp_sb_count: got %0d writes required %0d", obs_q.size(), exp_q.size()); else n_pass++;
    while (obs_q.size() > 0 && exp_q.size() > 0) begin
      o = obs_q.pop_front(); e = exp_q.pop_front(); n_checks++;
      if (o !== e) $display("FAIL byp_sb_write: got r%0d=%h required r%0d=%h", o[36:32], o[31:0], e[36:32], e[31:0]); else n_pass++;
    end
    obs_q.delete(); exp_q.delete();
  endtask

  task automatic test_reset_mid();
    logic [36:0] o, e;
    for (int i = 0; i < 3; i++) begin
      mem_we = 1'b1; mem_addr = 5'd20; mem_data = 32'(32'h900 + i);
      b_valid = 1'b1; b_addr = 5'(13 + i); b_data = 32'(32'h300 + i);
      exp_q.push_back({5'd20, 32'(32'h900 + i)});
      cyc();
    end
    n_checks++; if (pend_mask !== 32'hE000) $display("FAIL rstmid_pend_pre: got %h required 0000e000", pend_mask); else n_pass++;
    #1;
    reset_n = 1'b0;
    idle_inputs();
    #1;
    n_checks++; if (wb_we !== 1'b0) $display("FAIL rstmid_wb_we: got %b required 0", wb_we); else n_pass++;
    n_checks++; if (pend_mask !== 32'h0) $display("FAIL rstmid_pend: got %h required 0", pend_mask); else n_pass++;
    n_checks++; if (b_ready !== 1'b1) $display("FAIL rstmid_b_ready: got %b required 1", b_ready); else n_pass++;
    repeat (2) cyc();
    reset_n = 1'b1;
    repeat (6) cyc();
    n_checks++; if (pend_mask !== 32'h0) $display("FAIL rstmid_pend_after: got %h required 0", pend_mask); else n_pass++;
    n_checks++; if (obs_q.size() != exp_q.size()) $display("FAIL rstmid_sb_count: got %0d writes required %0d", obs_q.size(), exp_q.size()); else n_pass++;
    while (obs_q.size() > 0 && exp_q.size() > 0) begin
      o = obs_q.pop_front(); e = exp_q.pop_front(); n_checks++;
      if (o !== e) $display("FAIL rstmid_sb_write: got r%0d=%h required r%0d=%h", o[36:32], o[31:0], e[36:32], e[31:0]); else n_pass++;
    end
    obs_q.delete(); exp_q.delete();
  endtask

  initial begin
    test_reset();
    test_priority();
    test_full();
    test_starvation();
    test_r0();
    test_bypass();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
